// File: rtl/ym2149_seq_pkg.sv
// Shared definitions for the YM2149 register-stream sequencer.
// Optional feature macro: YM2149_SEQ_IRQ_EN (low-watermark interrupt).
package ym2149_seq_pkg;

    // Slave register word offsets
    localparam logic [1:0] REG_CTRL     = 2'd0;
    localparam logic [1:0] REG_STATUS   = 2'd1;
    localparam logic [1:0] REG_CMD      = 2'd2;
    localparam logic [1:0] REG_TICK_DIV = 2'd3;

    // CTRL bit positions
    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_CLR_BIT    = 1;
    localparam int CTRL_IRQ_EN_BIT = 2;
    localparam int CTRL_THR_LSB    = 8;
    localparam int CTRL_THR_MSB    = 15;

    // STATUS bit positions
    localparam int ST_LEVEL_MSB = 8;
    localparam int ST_EMPTY_BIT = 9;
    localparam int ST_FULL_BIT  = 10;
    localparam int ST_OVF_BIT   = 11;
    localparam int ST_BERR_BIT  = 12;
    localparam int ST_BUSY_BIT  = 13;

    // CMD entry fields
    localparam int CMD_DELAY_MSB = 31;
    localparam int CMD_DELAY_LSB = 16;
    localparam int CMD_REG_MSB   = 15;
    localparam int CMD_REG_LSB   = 8;
    localparam int CMD_VAL_MSB   = 7;
    localparam int CMD_VAL_LSB   = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2,
        ACK   = 2'd3
    } seq_state_e;

endpackage

// File: rtl/ym2149_seq_fifo.sv
// Entry FIFO for the sequencer: 32-bit wide, power-of-2 depth, with flush.
// A push into a full FIFO is only accepted when a pop happens the same cycle.
module ym2149_seq_fifo #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [31:0]   data_i,
    input  logic          pop_i,
    output logic [31:0]   data_o,
    output logic [AW:0]   level_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign level_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Storage array, written on accepted pushes
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers and occupancy; flush overrides any concurrent push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
        end
    end

endmodule

// File: rtl/ym2149_reg_sequencer.sv
// YM2149 register-stream player: Wishbone slave for CPU programming, timed
// entry FIFO, tick prescaler and a Wishbone master issuing PSG writes.
// Optional feature macro: YM2149_SEQ_IRQ_EN (adds irq port, CTRL[2], CTRL[15:8]).
//
// state | meaning
// IDLE  | no transaction; latch FIFO head when enabled and not empty
// WAIT  | counting down entry delay in ticks
// ISSUE | master strobe asserted, waiting for stall to drop
// ACK   | strobe accepted, cycle held until ack/err
module ym2149_reg_sequencer
    import ym2149_seq_pkg::*;
#(
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [31:0] PSG_BASE     = 32'h1000_1000,
    parameter logic [15:0] TICK_DIV_RST = 16'd50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  wbs_adr,
    input  logic [31:0] wbs_dat_w,
    output logic [31:0] wbs_dat_r,
    input  logic [3:0]  wbs_sel,
    input  logic        wbs_cyc,
    input  logic        wbs_stb,
    input  logic        wbs_we,
    output logic        wbs_ack,
    output logic        wbs_stall,
    output logic        wbs_err,
    output logic [31:0] wbm_adr,
    output logic [31:0] wbm_dat_w,
    output logic [3:0]  wbm_sel,
    output logic        wbm_cyc,
    output logic        wbm_stb,
    output logic        wbm_we,
    input  logic [31:0] wbm_dat_r,
    input  logic        wbm_ack,
    input  logic        wbm_stall,
    input  logic        wbm_err
`ifdef YM2149_SEQ_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic        acc, wr_ctrl, wr_status, wr_cmd, wr_tick, clear_req;
    logic        enable_q, clear_pend_q, clear_pend_d, overflow_q, bus_err_q, ack_q;
    logic [31:0] dat_r_q, rd_data, entry_q, entry_d, fifo_head;
    logic [15:0] tick_div_q, presc_q, div_m1, wait_q, wait_d;
    logic        push, flush, tick, fifo_pop, fifo_full, fifo_empty, ovf_evt, bus_err_evt;
    logic [AW:0] fifo_level;
    logic [8:0]  level9;
    seq_state_e  state_q, state_d;
    logic        unused_ok;

    assign unused_ok = ^{wbs_sel, wbm_dat_r};

    assign acc       = wbs_cyc && wbs_stb;
    assign wr_ctrl   = acc && wbs_we && (wbs_adr == REG_CTRL);
    assign wr_status = acc && wbs_we && (wbs_adr == REG_STATUS);
    assign wr_cmd    = acc && wbs_we && (wbs_adr == REG_CMD);
    assign wr_tick   = acc && wbs_we && (wbs_adr == REG_TICK_DIV);
    assign clear_req = wr_ctrl && wbs_dat_w[CTRL_CLR_BIT];

    // A clear only takes effect outside a bus transaction; until then it stays pending
    assign flush        = (clear_req || clear_pend_q) && (state_q == IDLE || state_q == WAIT);
    assign clear_pend_d = flush ? 1'b0 : (clear_req ? 1'b1 : clear_pend_q);
    assign push         = wr_cmd && !clear_pend_q;
    assign ovf_evt      = push && fifo_full && !fifo_pop;

    assign level9    = 9'(fifo_level);
    assign wbs_stall = 1'b0;
    assign wbs_err   = 1'b0;
    assign wbs_ack   = ack_q;
    assign wbs_dat_r = dat_r_q;

    assign div_m1 = (tick_div_q == 16'd0) ? 16'd0 : tick_div_q - 16'd1;
    assign tick   = enable_q && (presc_q >= div_m1);

    ym2149_seq_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .push_i  (push),
        .data_i  (wbs_dat_w),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .level_o (fifo_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef YM2149_SEQ_IRQ_EN
    logic       irq_en_q, irq_q;
    logic [7:0] thresh_q;

    // Low-watermark interrupt configuration and registered level compare
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en_q <= 1'b0;
            thresh_q <= 8'd0;
            irq_q    <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                irq_en_q <= wbs_dat_w[CTRL_IRQ_EN_BIT];
                thresh_q <= wbs_dat_w[CTRL_THR_MSB:CTRL_THR_LSB];
            end
            irq_q <= irq_en_q && (level9 <= {1'b0, thresh_q});
        end
    end
    assign irq = irq_q;
`endif

    // Slave read mux
    always_comb begin
        rd_data = '0;
        case (wbs_adr)
            REG_CTRL: begin
                rd_data[CTRL_EN_BIT] = enable_q;
`ifdef YM2149_SEQ_IRQ_EN
                rd_data[CTRL_IRQ_EN_BIT]           = irq_en_q;
                rd_data[CTRL_THR_MSB:CTRL_THR_LSB] = thresh_q;
`endif
            end
            REG_STATUS: begin
                rd_data[ST_LEVEL_MSB:0] = level9;
                rd_data[ST_EMPTY_BIT]   = fifo_empty;
                rd_data[ST_FULL_BIT]    = fifo_full;
                rd_data[ST_OVF_BIT]     = overflow_q;
                rd_data[ST_BERR_BIT]    = bus_err_q;
                rd_data[ST_BUSY_BIT]    = (state_q != IDLE);
            end
            REG_TICK_DIV: rd_data[15:0] = tick_div_q;
            default: ;
        endcase
    end

    // Slave registers, sticky flags and response pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q        <= 1'b0;
            dat_r_q      <= '0;
            enable_q     <= 1'b0;
            clear_pend_q <= 1'b0;
            tick_div_q   <= TICK_DIV_RST;
            overflow_q   <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            ack_q        <= acc;
            clear_pend_q <= clear_pend_d;
            if (acc) dat_r_q <= wbs_we ? 32'd0 : rd_data;
            if (wr_ctrl) enable_q <= wbs_dat_w[CTRL_EN_BIT];
            if (wr_tick) tick_div_q <= wbs_dat_w[15:0];
            if (ovf_evt) overflow_q <= 1'b1;
            else if (wr_status && wbs_dat_w[ST_OVF_BIT]) overflow_q <= 1'b0;
            if (bus_err_evt) bus_err_q <= 1'b1;
            else if (wr_status && wbs_dat_w[ST_BERR_BIT]) bus_err_q <= 1'b0;
        end
    end

    // Tick prescaler; a TICK_DIV write restarts the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else if (wr_tick) begin
            presc_q <= '0;
        end else if (enable_q) begin
            presc_q <= tick ? 16'd0 : presc_q + 16'd1;
        end
    end

    // FSM state, wait counter and latched entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wait_q  <= '0;
            entry_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            entry_q <= entry_d;
        end
    end

    // FSM next-state and master bus outputs
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        entry_d     = entry_q;
        fifo_pop    = 1'b0;
        bus_err_evt = 1'b0;
        wbm_cyc     = 1'b0;
        wbm_stb     = 1'b0;
        wbm_we      = 1'b0;
        wbm_sel     = 4'b0000;
        wbm_adr     = '0;
        wbm_dat_w   = '0;
        case (state_q)
            IDLE: begin
                if (enable_q && !fifo_empty && !flush) begin
                    entry_d = fifo_head;
                    wait_d  = fifo_head[CMD_DELAY_MSB:CMD_DELAY_LSB];
                    state_d = (fifo_head[CMD_DELAY_MSB:CMD_DELAY_LSB] == 16'd0) ? ISSUE : WAIT;
                end
            end
            WAIT: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (tick) begin
                    wait_d = wait_q - 16'd1;
                    if (wait_q == 16'd1) state_d = ISSUE;
                end
            end
            ISSUE, ACK: begin
                wbm_cyc   = 1'b1;
                wbm_stb   = (state_q == ISSUE);
                wbm_we    = (state_q == ISSUE);
                wbm_sel   = 4'b0001;
                wbm_adr   = PSG_BASE + {22'd0, entry_q[CMD_REG_MSB:CMD_REG_LSB], 2'b00};
                wbm_dat_w = {24'd0, entry_q[CMD_VAL_MSB:CMD_VAL_LSB]};
                if (state_q == ISSUE && wbm_stall) begin
                    state_d = ISSUE;
                end else if (wbm_ack || wbm_err) begin
                    fifo_pop    = 1'b1;
                    bus_err_evt = wbm_err;
                    state_d     = IDLE;
                end else begin
                    state_d = ACK;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ym2149_reg_sequencer.sv
// Scoreboard bench for ym2149_reg_sequencer: stimulus pushes expected master
// writes and slave read data into queues, a monitor pops and compares them.
// Optional feature macro: YM2149_SEQ_IRQ_EN (enables the irq checks).
module tb_ym2149_reg_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  wbs_adr = '0;
    logic [31:0] wbs_dat_w = '0;
    logic [31:0] wbs_dat_r;
    logic [3:0]  wbs_sel = 4'hF;
    logic        wbs_cyc = 1'b0, wbs_stb = 1'b0, wbs_we = 1'b0;
    logic        wbs_ack, wbs_stall, wbs_err;
    logic [31:0] wbm_adr, wbm_dat_w;
    logic [3:0]  wbm_sel;
    logic        wbm_cyc, wbm_stb, wbm_we;
    logic [31:0] wbm_dat_r = '0;
    logic        wbm_ack = 1'b0, wbm_stall = 1'b0, wbm_err = 1'b0;
`ifdef YM2149_SEQ_IRQ_EN
    logic        irq;
`endif

    ym2149_reg_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .wbs_adr(wbs_adr), .wbs_dat_w(wbs_dat_w), .wbs_dat_r(wbs_dat_r), .wbs_sel(wbs_sel),
        .wbs_cyc(wbs_cyc), .wbs_stb(wbs_stb), .wbs_we(wbs_we),
        .wbs_ack(wbs_ack), .wbs_stall(wbs_stall), .wbs_err(wbs_err),
        .wbm_adr(wbm_adr), .wbm_dat_w(wbm_dat_w), .wbm_sel(wbm_sel),
        .wbm_cyc(wbm_cyc), .wbm_stb(wbm_stb), .wbm_we(wbm_we),
        .wbm_dat_r(wbm_dat_r), .wbm_ack(wbm_ack), .wbm_stall(wbm_stall), .wbm_err(wbm_err)
`ifdef YM2149_SEQ_IRQ_EN
        , .irq(irq)
`endif
    );

    always #10 clk = ~clk;

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    int checks = 0;
    int errors = 0;
    int t_ref = 0;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        int          lo;
        int          hi;
    } mw_t;

    typedef struct {
        bit          is_rd;
        logic [31:0] exp;
        string       name;
    } acc_t;

    mw_t  exp_mw[$];
    acc_t exp_acc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Master-side responder: optional stall cycles, configurable ack latency, one-shot err
    int stall_left = 0, stall_cnt = 0, resp_delay = 1;
    bit err_next = 1'b0;
    initial begin : responder
        bit pend, pend_err;
        int pend_cnt;
        pend = 1'b0; pend_err = 1'b0; pend_cnt = 0;
        forever begin
            @(negedge clk);
            wbm_ack = 1'b0;
            wbm_err = 1'b0;
            if (pend) begin
                if (pend_cnt <= 1) begin
                    if (pend_err) wbm_err = 1'b1;
                    else          wbm_ack = 1'b1;
                    pend = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
            if (wbm_cyc && wbm_stb) begin
                if (stall_left > 0) begin
                    wbm_stall = 1'b1;
                    stall_left--;
                    stall_cnt++;
                end else begin
                    wbm_stall = 1'b0;
                    pend = 1'b1;
                    pend_cnt = resp_delay;
                    pend_err = err_next;
                    err_next = 1'b0;
                end
            end else begin
                wbm_stall = 1'b0;
            end
        end
    end

    // Monitor: compares accepted master writes and slave read responses against the queues
    initial begin : monitor
        mw_t  m;
        acc_t a;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && wbm_cyc && wbm_stb && !wbm_stall) begin
                if (exp_mw.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mw_unexpected: got adr %h dat %h, required no write", wbm_adr, wbm_dat_w);
                end else begin
                    m = exp_mw.pop_front();
                    chk("mw_adr", wbm_adr, m.adr);
                    chk("mw_dat", wbm_dat_w, m.dat);
                    chk("mw_we_sel", {27'd0, wbm_we, wbm_sel}, 32'h11);
                    if (m.lo >= 0) begin
                        checks++;
                        if ((cyc_n - t_ref) < m.lo || (cyc_n - t_ref) > m.hi) begin
                            errors++;
                            $display("FAIL mw_timing: got %0d cycles, required %0d..%0d", cyc_n - t_ref, m.lo, m.hi);
                        end
                    end
                end
            end
            if (rst_n && wbs_ack) begin
                if (exp_acc.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ack_unexpected: got ack, required none");
                end else begin
                    a = exp_acc.pop_front();
                    if (a.is_rd) chk(a.name, wbs_dat_r, a.exp);
                    else         chk("wr_ack_err", {31'd0, wbs_err}, 32'd0);
                end
            end
        end
    end

    task automatic bus(input bit we, input logic [1:0] adr, input logic [31:0] dat,
                       input logic [31:0] exp, input string name);
        acc_t a;
        a.is_rd = !we;
        a.exp   = exp;
        a.name  = name;
        exp_acc.push_back(a);
        @(negedge clk);
        wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = we; wbs_adr = adr; wbs_dat_w = dat;
        @(negedge clk);
        wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
    endtask

    task automatic wr(input logic [1:0] adr, input logic [31:0] dat);
        bus(1'b1, adr, dat, 32'd0, "wr");
    endtask

    task automatic rd(input logic [1:0] adr, input logic [31:0] exp, input string name);
        bus(1'b0, adr, 32'd0, exp, name);
    endtask

    task automatic push_mw(input logic [31:0] adr, input logic [31:0] dat, input int lo, input int hi);
        mw_t m;
        m.adr = adr; m.dat = dat; m.lo = lo; m.hi = hi;
        exp_mw.push_back(m);
    endtask

    task automatic wait_done(input string name, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            #1;
            ok = (exp_mw.size() == 0) && !wbm_cyc;
        end
        chk(name, {31'd0, ok}, 32'd1);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        bit seen;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_wb_ctl", {28'd0, wbm_cyc, wbm_stb, wbm_we, wbs_ack}, 32'd0);
        chk("rst_wbm_adr", wbm_adr, 32'd0);
        rd(2'd1, 32'h0000_0200, "rst_status");
        rd(2'd0, 32'h0000_0000, "rst_ctrl");
        rd(2'd3, 32'h0000_C350, "rst_tick_div");

        // Delay-0 entry issues shortly after enable
        wr(2'd2, {16'd0, 8'd7, 8'h38});
        push_mw(32'h1000_101C, 32'h38, 0, 2);
        wr(2'd0, 32'd1);
        t_ref = cyc_n;
        wait_done("t1_done", 50);
        rd(2'd1, 32'h0000_0200, "t1_status");

        // Delay of 3 ticks at TICK_DIV=10
        wr(2'd0, 32'd0);
        wr(2'd3, 32'd10);
        wr(2'd2, {16'd3, 8'd0, 8'h55});
        push_mw(32'h1000_1000, 32'h55, 20, 40);
        wr(2'd0, 32'd1);
        t_ref = cyc_n;
        repeat (5) @(negedge clk);
        rd(2'd1, 32'h0000_2001, "t2_busy_wait");
        wait_done("t2_done", 100);
        rd(2'd1, 32'h0000_0200, "t2_status");

        // Overflow with 17 pushes, W1C, clear while idle
        wr(2'd0, 32'd0);
        for (int i = 0; i < 17; i++) wr(2'd2, {16'd0, 8'(i), 8'(i)});
        rd(2'd1, 32'h0000_0C10, "t3_full_ovf");
        wr(2'd1, 32'h0000_0800);
        rd(2'd1, 32'h0000_0410, "t3_ovf_w1c");
        wr(2'd0, 32'd2);
        rd(2'd1, 32'h0000_0200, "t3_cleared");
        rd(2'd0, 32'h0000_0000, "t3_clr_reads0");

        // Optional CTRL bits
        wr(2'd0, 32'h0000_FF04);
`ifdef YM2149_SEQ_IRQ_EN
        rd(2'd0, 32'h0000_FF04, "ctrl_opt_bits");
`else
        rd(2'd0, 32'h0000_0000, "ctrl_opt_bits");
`endif
        wr(2'd0, 32'd0);

        // Stall 5 cycles then err; second entry still proceeds
        wr(2'd2, {16'd0, 8'd3, 8'hAA});
        wr(2'd2, {16'd0, 8'd4, 8'hBB});
        push_mw(32'h1000_100C, 32'hAA, -1, -1);
        push_mw(32'h1000_1010, 32'hBB, -1, -1);
        stall_left = 5;
        stall_cnt  = 0;
        err_next   = 1'b1;
        wr(2'd0, 32'd1);
        wait_done("t4_done", 100);
        chk("t4_stall_cycles", 32'(stall_cnt), 32'd5);
        rd(2'd1, 32'h0000_1200, "t4_bus_err");
        wr(2'd1, 32'h0000_1000);
        rd(2'd1, 32'h0000_0200, "t4_bus_err_w1c");

        // Clear while in ACK with delayed ack; later push is discarded
        wr(2'd0, 32'd0);
        wr(2'd2, {16'd0, 8'd1, 8'h11});
        wr(2'd2, {16'd0, 8'd2, 8'h22});
        wr(2'd2, {16'd0, 8'd3, 8'h33});
        push_mw(32'h1000_1004, 32'h11, -1, -1);
        resp_delay = 4;
        wr(2'd0, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            #1;
            seen = wbm_cyc && !wbm_stb;
        end
        chk("t5_reach_ack", {31'd0, seen}, 32'd1);
        wr(2'd0, 32'd3);
        wr(2'd2, {16'd0, 8'd9, 8'h99});
        repeat (20) @(negedge clk);
        rd(2'd1, 32'h0000_0200, "t5_flushed");
        rd(2'd0, 32'h0000_0001, "t5_ctrl");
        chk("t5_mw_drained", 32'(exp_mw.size()), 32'd0);
        resp_delay = 1;

`ifdef YM2149_SEQ_IRQ_EN
        // Low-watermark interrupt, threshold 2
        wr(2'd0, 32'd0);
        for (int i = 0; i < 4; i++) wr(2'd2, {16'd0, 8'(5 + i), 8'(8'h60 + i)});
        wr(2'd0, 32'h0000_0204);
        repeat (2) @(negedge clk);
        chk("irq_level4", {31'd0, irq}, 32'd0);
        for (int i = 0; i < 4; i++) push_mw(32'h1000_1014 + 32'(4 * i), 32'h60 + 32'(i), -1, -1);
        wr(2'd0, 32'h0000_0205);
        wait_done("irq_drain_done", 100);
        repeat (2) @(negedge clk);
        chk("irq_level0", {31'd0, irq}, 32'd1);
        wr(2'd0, 32'h0000_0204);
        wr(2'd2, {16'd0, 8'd1, 8'h01});
        wr(2'd2, {16'd0, 8'd1, 8'h02});
        repeat (2) @(negedge clk);
        chk("irq_level2", {31'd0, irq}, 32'd1);
        wr(2'd2, {16'd0, 8'd1, 8'h03});
        repeat (2) @(negedge clk);
        chk("irq_level3", {31'd0, irq}, 32'd0);
        wr(2'd0, 32'd2);
`endif

        repeat (4) @(negedge clk);
        chk("acc_drained", 32'(exp_acc.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
